updown_counter_display: RTL and testbench
=========================================

// Module: updown_counter_display
// PURPOSE
//   Multi-digit up/down counter with a built-in rate prescaler and a multiplexed
//   active-low 7-segment driver. It replaces the single-digit counter/display top:
//   NDIG digits, selectable decimal or hex digit modulus, run/pause enable, sync clear,
//   wrap pulse, and time-multiplexed digit scanning instead of all digits driven alike.
// PARAMETERS
//   NDIG      4           number of digits (1..8); q width = 4*NDIG
//   RATE_DIV  50_000_000  clk cycles per count tick (>=2); 1 Hz at 50 MHz
//   SCAN_DIV  50_000      clk cycles each digit is displayed (>=1)
//   BCD       1           1 = each digit counts 0..9; 0 = each digit counts 0..F
// PORTS
//   clk   in   1       system clock, all logic on rising edge
//   rst   in   1       reset, asynchronous, active-high
//   en    in   1       count enable (1 = run, 0 = pause)
//   dir   in   1       direction (1 = up, 0 = down)
//   clr   in   1       synchronous clear of counter and prescaler
//   q     out  4*NDIG  counter value, digit i in q[4i+3:4i], digit 0 = LSD
//   cy    out  1       one-clk pulse on full wrap (up past max, down past zero)
//   segn  out  7       active-low segments {g,f,e,d,c,b,a} of the selected digit
//   dign  out  NDIG    active-low digit select, exactly one bit low
// BEHAVIOUR
//   - Reset (async, any time incl. mid-count): q=0, cy=0, prescaler=0, scan index=0,
//     dign = ~1 (digit 0 on), segn = 7'b1000000 ("0"); en/dir/clr regs = 0.
//   - en, dir, clr registered once on clk: 1-cycle latency from pins to effect.
//   - Prescaler counts 0..RATE_DIV-1, wraps; tick = 1 for one clk when at RATE_DIV-1.
//     Runs regardless of en; cleared to 0 by clr_r.
//   - Counter update on tick when en_r=1 (priority: rst > clr_r > tick):
//     up: digit at MAX (9 if BCD else F) -> 0 and carries into next digit.
//     down: digit at 0 -> MAX and borrows from next digit.
//     All digits MAX, up -> all 0; all 0, down -> all MAX; cy=1 in the same cycle
//     q takes the wrapped value, 0 in every other cycle.
//   - clr_r=1: q=0 next cycle, cy=0, even if tick coincides.
//   - dir change applies at the next tick; no effect between ticks.
//   - en_r=0: q holds, cy=0; scanning continues.
//   - Scan: scan counter 0..SCAN_DIV-1; at terminal count index advances
//     0,1..NDIG-1,0. dign = ~(1<<index); segn = seg pattern of q digit[index],
//     both registered, change in same cycle (no ghosting skew). Hex glyphs A-F used
//     only when BCD=0.
//   - Input values outside MAX never arise; q is only written by this logic.
// CONFIGURATION
//   BLANK_LEADING_ZERO_EN defined: digit at index i>0 whose value and all higher
//     digits are 0 is shown blank (segn=7'h7F; dign still asserted). Digit 0 never blanked.
//   Not defined: every digit always displays its value, including leading zeros.
// STRUCTURE
//   - Shared package counter_pkg: segment patterns 0-F (active-low), SEG_BLANK=7'h7F,
//     digit width constant DIGW=4, BCD/HEX max-digit constants.
//   - One sub-module: existing hex2seg (4-bit -> 7-bit active-low), single instance
//     on the muxed digit. Prescaler, digit chain and scanner stay inline.
// TESTING  (bench params NDIG=2, RATE_DIV=4, SCAN_DIV=2 unless stated)
//   1. rst pulse mid-count at q=8'h37 -> q=0, cy=0 immediately (no clk), dign=2'b10,
//      segn=7'b1000000; counting resumes 4 clk after release.
//   2. BCD=1, en=1, dir=1 from 0: after 10 ticks q=8'h10; after 100 ticks q=8'h00
//      with cy=1 for exactly one clk; BCD=0: after 16 ticks q=8'h10.
//   3. q=0, dir=0, one tick -> q=8'h99, cy=1 (BCD=1); BCD=0 -> q=8'hFF, cy=1.
//   4. clr asserted so clr_r coincides with tick at q=8'h99, dir=1 -> q=8'h00, cy=0;
//      next tick RATE_DIV clk later -> q=8'h01.
//   5. en=0 for 20 ticks at q=8'h42 -> q stays 8'h42, cy=0, dign keeps toggling
//      2'b10/2'b01 every 2 clk.
//   6. q=8'h37: segn alternates "7"/"3" with dign 10/01; BLANK_LEADING_ZERO_EN with
//      q=8'h05: digit 1 segn=7'h7F, digit 0 shows "5"; without macro digit 1 shows "0".

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and active-low 7-segment glyph table for the up/down counter display.
package counter_pkg;

    localparam int         DIGW      = 4;
    localparam logic [3:0] MAX_BCD   = 4'd9;
    localparam logic [3:0] MAX_HEX   = 4'hF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex2seg.sv
// Combinational 4-bit value to active-low 7-segment pattern decoder.
module hex2seg
    import counter_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] segn
);

    assign segn = seg_of(hex);

endmodule

// File: rtl/updown_counter_display.sv
// Multi-digit BCD/hex up/down counter with rate prescaler and multiplexed 7-segment scan.
// Optional build macro: BLANK_LEADING_ZERO_EN blanks leading zero digits above digit 0.
module updown_counter_display
    import counter_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int RATE_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000,
    parameter int BCD      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 dir,
    input  logic                 clr,
    output logic [4*NDIG-1:0]    q,
    output logic                 cy,
    output logic [6:0]           segn,
    output logic [NDIG-1:0]      dign
);

    localparam int PRE_W  = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(RATE_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NDIG - 1);
    localparam logic [DIGW-1:0]   DMAX      = (BCD != 0) ? MAX_BCD : MAX_HEX;

    logic                   en_q, dir_q, clr_q;
    logic [PRE_W-1:0]       pre_q, pre_d;
    logic [DIGW*NDIG-1:0]   cnt_q, cnt_d;
    logic                   cy_q, cy_d;
    logic [SCAN_W-1:0]      scan_q, scan_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [6:0]             segn_q, segn_d;
    logic [NDIG-1:0]        dign_q, dign_d;
    logic                   tick;
    logic                   carry;
    logic [DIGW-1:0]        dig;
    logic [DIGW-1:0]        sel_dig;
    logic                   sel_blank;
    logic [6:0]             seg_raw;
    logic [NDIG-1:0]        lead_zero;

    assign tick = (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q + 1'b1;
        if (clr_q || tick) begin
            pre_d = '0;
        end
    end

    // Ripple the carry/borrow through the digit chain; what survives the top digit is the wrap.
    always_comb begin
        cnt_d = cnt_q;
        cy_d  = 1'b0;
        carry = 1'b1;
        dig   = '0;
        if (clr_q) begin
            cnt_d = '0;
        end else if (tick && en_q) begin
            for (int i = 0; i < NDIG; i++) begin
                dig = cnt_q[DIGW*i +: DIGW];
                if (carry) begin
                    if (dir_q) begin
                        if (dig == DMAX) begin
                            dig = '0;
                        end else begin
                            dig   = dig + 1'b1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (dig == '0) begin
                            dig = DMAX;
                        end else begin
                            dig   = dig - 1'b1;
                            carry = 1'b0;
                        end
                    end
                end
                cnt_d[DIGW*i +: DIGW] = dig;
            end
            cy_d = carry;
        end
    end

`ifdef BLANK_LEADING_ZERO_EN
    logic zero_above;
    always_comb begin
        lead_zero  = '0;
        zero_above = 1'b1;
        for (int i = NDIG - 1; i > 0; i--) begin
            zero_above   = zero_above && (cnt_q[DIGW*i +: DIGW] == '0);
            lead_zero[i] = zero_above;
        end
    end
`else
    assign lead_zero = '0;
`endif

    // Segments and digit strobe are both taken from the next index so they switch together.
    always_comb begin
        scan_d    = scan_q + 1'b1;
        idx_d     = idx_q;
        sel_dig   = '0;
        sel_blank = 1'b0;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        for (int i = 0; i < NDIG; i++) begin
            if (idx_d == IDX_W'(i)) begin
                sel_dig   = cnt_q[DIGW*i +: DIGW];
                sel_blank = lead_zero[i];
            end
        end
        dign_d = ~(NDIG'(1) << idx_d);
        segn_d = sel_blank ? SEG_BLANK : seg_raw;
    end

    hex2seg u_hex2seg (
        .hex  (sel_dig),
        .segn (seg_raw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= 1'b0;
            dir_q  <= 1'b0;
            clr_q  <= 1'b0;
            pre_q  <= '0;
            cnt_q  <= '0;
            cy_q   <= 1'b0;
            scan_q <= '0;
            idx_q  <= '0;
            segn_q <= SEG_ZERO;
            dign_q <= ~NDIG'(1);
        end else begin
            en_q   <= en;
            dir_q  <= dir;
            clr_q  <= clr;
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            cy_q   <= cy_d;
            scan_q <= scan_d;
            idx_q  <= idx_d;
            segn_q <= segn_d;
            dign_q <= dign_d;
        end
    end

    assign q    = cnt_q;
    assign cy   = cy_q;
    assign segn = segn_q;
    assign dign = dign_q;

endmodule

// File: tb/tb_updown_counter_display.sv
// Directed scoreboard bench for updown_counter_display: decimal and hex instances side by side.
module tb_updown_counter_display;

    logic       clk = 1'b0;
    logic       rst, en, dir, clr;
    logic [7:0] q_b, q_h;
    logic       cy_b, cy_h;
    logic [6:0] segn_b, segn_h;
    logic [1:0] dign_b, dign_h;

    int cmp_cnt = 0;
    int mis_cnt = 0;
    int cyc     = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    updown_counter_display #(.NDIG(2), .RATE_DIV(4), .SCAN_DIV(2), .BCD(1)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr),
        .q(q_b), .cy(cy_b), .segn(segn_b), .dign(dign_b)
    );

    updown_counter_display #(.NDIG(2), .RATE_DIV(4), .SCAN_DIV(2), .BCD(0)) dut_hex (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr),
        .q(q_h), .cy(cy_h), .segn(segn_h), .dign(dign_h)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic e, input logic d, input logic c);
        rst = r;
        en  = e;
        dir = d;
        clr = c;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic expectVal(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] obs);
        exp_t e;
        cmp_cnt++;
        if (sb.size() == 0) begin
            mis_cnt++;
            $display("[TB] FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                mis_cnt++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    function automatic logic [1:0] dign_at(input int c);
        return ((c >> 1) & 1) != 0 ? 2'b01 : 2'b10;
    endfunction

    initial begin
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        step(2);
        expectVal("reset_q", 32'h00);       checkOutput(32'(q_b));
        expectVal("reset_cy", 32'h0);       checkOutput(32'(cy_b));
        expectVal("reset_dign", 32'h2);     checkOutput(32'(dign_b));
        expectVal("reset_segn", 32'h40);    checkOutput(32'(segn_b));

        // Count up from zero in both moduli.
        rst = 1'b0;
        cyc = 0;
        step(40);
        expectVal("bcd_10_ticks", 32'h10);  checkOutput(32'(q_b));
        expectVal("hex_10_ticks", 32'h0A);  checkOutput(32'(q_h));
        step(24);
        expectVal("bcd_16_ticks", 32'h16);  checkOutput(32'(q_b));
        expectVal("hex_16_ticks", 32'h10);  checkOutput(32'(q_h));
        step(335);
        expectVal("bcd_99_ticks", 32'h99);  checkOutput(32'(q_b));
        expectVal("bcd_cy_before", 32'h0);  checkOutput(32'(cy_b));
        step(1);
        expectVal("bcd_wrap_q", 32'h00);    checkOutput(32'(q_b));
        expectVal("bcd_wrap_cy", 32'h1);    checkOutput(32'(cy_b));
        expectVal("hex_100_ticks", 32'h64); checkOutput(32'(q_h));
        expectVal("hex_cy_none", 32'h0);    checkOutput(32'(cy_h));
        step(1);
        expectVal("bcd_cy_after", 32'h0);   checkOutput(32'(cy_b));

        // Display scan at 37, then asynchronous reset between clock edges.
        step(147);
        expectVal("bcd_37", 32'h37);        checkOutput(32'(q_b));
        step(1);
        expectVal("scan_d0_dign", 32'h2);   checkOutput(32'(dign_b));
        expectVal("scan_d0_seg7", 32'h78);  checkOutput(32'(segn_b));
        step(1);
        expectVal("scan_d1_dign", 32'h1);   checkOutput(32'(dign_b));
        expectVal("scan_d1_seg3", 32'h30);  checkOutput(32'(segn_b));
        #2 rst = 1'b1;
        #1;
        expectVal("async_rst_q", 32'h00);   checkOutput(32'(q_b));
        expectVal("async_rst_cy", 32'h0);   checkOutput(32'(cy_b));
        expectVal("async_rst_dign", 32'h2); checkOutput(32'(dign_b));
        expectVal("async_rst_segn", 32'h40);checkOutput(32'(segn_b));
        expectVal("async_rst_hex_q", 32'h0);checkOutput(32'(q_h));
        step(1);
        rst = 1'b0;
        cyc = 0;
        step(3);
        expectVal("resume_hold", 32'h00);   checkOutput(32'(q_b));
        step(1);
        expectVal("resume_first", 32'h01);  checkOutput(32'(q_b));

        // Down from zero wraps to all-MAX with carry pulse.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        step(2);
        rst = 1'b0;
        cyc = 0;
        step(4);
        expectVal("down_bcd_q", 32'h99);    checkOutput(32'(q_b));
        expectVal("down_bcd_cy", 32'h1);    checkOutput(32'(cy_b));
        expectVal("down_hex_q", 32'hFF);    checkOutput(32'(q_h));
        expectVal("down_hex_cy", 32'h1);    checkOutput(32'(cy_h));

        // Clear lands on the same edge as an up-wrap tick.
        dir = 1'b1;
        step(2);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(1);
        expectVal("clr_bcd_q", 32'h00);     checkOutput(32'(q_b));
        expectVal("clr_bcd_cy", 32'h0);     checkOutput(32'(cy_b));
        expectVal("clr_hex_q", 32'h00);     checkOutput(32'(q_h));
        expectVal("clr_hex_cy", 32'h0);     checkOutput(32'(cy_h));
        step(3);
        expectVal("clr_hold", 32'h00);      checkOutput(32'(q_b));
        step(1);
        expectVal("clr_next_tick", 32'h01); checkOutput(32'(q_b));

        // Pause at 42 for 20 ticks while scanning carries on.
        step(164);
        expectVal("pause_start", 32'h42);   checkOutput(32'(q_b));
        en = 1'b0;
        for (int k = 0; k < 80; k++) begin
            step(1);
            expectVal("pause_q", 32'h42);              checkOutput(32'(q_b));
            expectVal("pause_cy", 32'h0);              checkOutput(32'(cy_b));
            expectVal("pause_dign", 32'(dign_at(cyc)));checkOutput(32'(dign_b));
        end

        // Leading-zero display at 05.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        step(2);
        rst = 1'b0;
        cyc = 0;
        step(20);
        expectVal("lz_q", 32'h05);          checkOutput(32'(q_b));
        step(1);
        expectVal("lz_d0_dign", 32'h2);     checkOutput(32'(dign_b));
        expectVal("lz_d0_seg5", 32'h12);    checkOutput(32'(segn_b));
        step(1);
        expectVal("lz_d1_dign", 32'h1);     checkOutput(32'(dign_b));
`ifdef BLANK_LEADING_ZERO_EN
        expectVal("lz_d1_blank", 32'h7F);   checkOutput(32'(segn_b));
`else
        expectVal("lz_d1_zero", 32'h40);    checkOutput(32'(segn_b));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
